cp0_exc_unit: RTL and testbench

Coprocessor-0 block at the M stage: the consumer end of the exception code that the pipeline registers carry forward from IF.
- Collects the M-stage exception code and the external hardware interrupts.
- Decides exception/interrupt entry and drives the flush pulses ActivateCP0 (entry) and CoolCP0 (eret) back to every pipeline register.
- Holds SR, Cause, EPC and PRId, and serves mfc0/mtc0.

---
 rtl/cp0_exc_unit.sv | 118 +++++++++++
 tb/tb_cp0_exc_unit.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/cp0_exc_unit.sv
// Coprocessor-0 at the M stage: SR/Cause/EPC/PRId, exception and interrupt entry,
// eret handling, and the ActivateCP0/CoolCP0 flush pulses to the pipeline registers.
module cp0_exc_unit #(
    parameter logic [31:0] PRID_VAL   = 32'h4255_4141,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [4:0]  ExcCode_M,
    input  logic [31:0] PC_M,
    input  logic        BD_M,
    input  logic [5:0]  HWInt,
    input  logic        WE,
    input  logic [4:0]  Addr,
    input  logic [31:0] DIn,
    input  logic        EXLClr,
    output logic [31:0] DOut,
    output logic [31:0] EPC_Out,
    output logic [31:0] HandlerPC,
    output logic        ActivateCP0,
    output logic        CoolCP0
);

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    // Only the architecturally defined fields are stored; everything else reads 0.
    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [29:0] epc_q, epc_d;

    logic int_req;
    logic exc_req;
    logic unused_pc_bits;

    assign unused_pc_bits = ^PC_M[1:0];

    assign int_req     = (|(HWInt & im_q)) & ie_q & ~exl_q;
    assign exc_req     = (ExcCode_M != 5'd0) & ~exl_q;
    assign ActivateCP0 = int_req | exc_req;
    assign CoolCP0     = EXLClr & ~ActivateCP0;

    assign EPC_Out   = {epc_q, 2'b00};
    assign HandlerPC = HANDLER_PC;

    always_comb begin
        // NOTE: every next-state signal takes its hold value first, so no path leaves it unassigned (no latches).
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        ip_d       = HWInt;

        if (ActivateCP0) begin
            exl_d      = 1'b1;
            exc_code_d = int_req ? 5'd0 : ExcCode_M;
            bd_d       = BD_M;
            epc_d      = BD_M ? (PC_M[31:2] - 30'd1) : PC_M[31:2];
        end else begin
            if (WE) begin
                case (Addr)
                    ADDR_SR: begin
                        im_d  = DIn[15:10];
                        exl_d = DIn[1];
                        ie_d  = DIn[0];
                    end
                    ADDR_EPC: epc_d = DIn[31:2];
                    default: ;
                endcase
            end
            // eret clears EXL after any same-cycle mtc0 to SR has been applied.
            if (CoolCP0) begin
                exl_d = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_q       <= '0;
            exc_code_q <= '0;
            epc_q      <= '0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ip_q       <= ip_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
        end
    end

    always_comb begin
        DOut = 32'd0;
        case (Addr)
            ADDR_SR:    DOut = {16'd0, im_q, 8'd0, exl_q, ie_q};
            ADDR_CAUSE: DOut = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'b00};
            ADDR_EPC:   DOut = {epc_q, 2'b00};
            ADDR_PRID:  DOut = PRID_VAL;
            default:    DOut = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed bench for cp0_exc_unit: a per-cycle vector table with hand-computed
// expectations, followed by a hand-written asynchronous mid-handler reset sequence.
module tb_cp0_exc_unit;

    logic        Clk;
    logic        Rst;
    logic [4:0]  ExcCode_M;
    logic [31:0] PC_M;
    logic        BD_M;
    logic [5:0]  HWInt;
    logic        WE;
    logic [4:0]  Addr;
    logic [31:0] DIn;
    logic        EXLClr;
    logic [31:0] DOut;
    logic [31:0] EPC_Out;
    logic [31:0] HandlerPC;
    logic        ActivateCP0;
    logic        CoolCP0;

    cp0_exc_unit dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .ExcCode_M  (ExcCode_M),
        .PC_M       (PC_M),
        .BD_M       (BD_M),
        .HWInt      (HWInt),
        .WE         (WE),
        .Addr       (Addr),
        .DIn        (DIn),
        .EXLClr     (EXLClr),
        .DOut       (DOut),
        .EPC_Out    (EPC_Out),
        .HandlerPC  (HandlerPC),
        .ActivateCP0(ActivateCP0),
        .CoolCP0    (CoolCP0)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] din;
        logic [4:0]  exc;
        logic [31:0] pc;
        logic        bd;
        logic [5:0]  hw;
        logic        exlclr;
        logic [31:0] exp_dout;
        logic        exp_act;
        logic        exp_cool;
        logic [31:0] exp_epc;
    } vec_t;

    vec_t vecs[$];
    int   checks;
    int   failures;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [4:0] addr, input logic [31:0] din,
                                input logic [4:0] exc, input logic [31:0] pc, input logic bd,
                                input logic [5:0] hw, input logic exlclr,
                                input logic [31:0] exp_dout, input logic exp_act,
                                input logic exp_cool, input logic [31:0] exp_epc);
        vec_t v;
        v.we = we; v.addr = addr; v.din = din; v.exc = exc; v.pc = pc; v.bd = bd;
        v.hw = hw; v.exlclr = exlclr; v.exp_dout = exp_dout; v.exp_act = exp_act;
        v.exp_cool = exp_cool; v.exp_epc = exp_epc;
        return v;
    endfunction

    initial begin
        checks   = 0;
        failures = 0;

        //          we  addr   din            exc    pc             bd  hw         clr   dout           act  cool  epc
        vecs.push_back(mk(0, 5'd12, 32'h0,         5'd0,  32'h0,         0, 6'b000000, 0,    32'h0000_0000, 0,   0,    32'h0000_0000));
        vecs.push_back(mk(0, 5'd13, 32'h0,         5'd0,  32'h0,         0, 6'b000000, 0,    32'h0000_0000, 0,   0,    32'h0000_0000));
        vecs.push_back(mk(0, 5'd14, 32'h0,         5'd0,  32'h0,         0, 6'b000000, 0,    32'h0000_0000, 0,   0,    32'h0000_0000));
        vecs.push_back(mk(0, 5'd15, 32'h0,         5'd0,  32'h0,         0, 6'b000000, 0,    32'h4255_4141, 0,   0,    32'h0000_0000));
        // mtc0 SR = 0x401, then interrupt on line 0
        vecs.push_back(mk(1, 5'd12, 32'h0000_0401, 5'd0,  32'h0,         0, 6'b000000, 0,    32'h0000_0000, 0,   0,    32'h0000_0000));
        vecs.push_back(mk(0, 5'd12, 32'h0,         5'd0,  32'h0000_2000, 0, 6'b000001, 0,    32'h0000_0401, 1,   0,    32'h0000_0000));
        vecs.push_back(mk(0, 5'd12, 32'h0,         5'd0,  32'h0,         0, 6'b000001, 0,    32'h0000_0403, 0,   0,    32'h0000_2000));
        vecs.push_back(mk(0, 5'd13, 32'h0,         5'd0,  32'h0,         0, 6'b000000, 0,    32'h0000_0400, 0,   0,    32'h0000_2000));
        vecs.push_back(mk(0, 5'd12, 32'h0,         5'd0,  32'h0,         0, 6'b000000, 1,    32'h0000_0403, 0,   1,    32'h0000_2000));
        // IE = 0, exception code 10 in a delay slot
        vecs.push_back(mk(1, 5'd12, 32'h0000_0000, 5'd0,  32'h0,         0, 6'b000000, 0,    32'h0000_0401, 0,   0,    32'h0000_2000));
        vecs.push_back(mk(0, 5'd12, 32'h0,         5'd10, 32'h0000_3008, 1, 6'b000000, 0,    32'h0000_0000, 1,   0,    32'h0000_2000));
        vecs.push_back(mk(0, 5'd13, 32'h0,         5'd12, 32'h0000_4000, 0, 6'b000000, 0,    32'h8000_0028, 0,   0,    32'h0000_3004));
        vecs.push_back(mk(0, 5'd12, 32'h0,         5'd0,  32'h0,         0, 6'b000000, 0,    32'h0000_0002, 0,   0,    32'h0000_3004));
        vecs.push_back(mk(0, 5'd14, 32'h0,         5'd0,  32'h0,         0, 6'b000000, 1,    32'h0000_3004, 0,   1,    32'h0000_3004));
        // interrupt beats exception; same-cycle mtc0 EPC dropped
        vecs.push_back(mk(1, 5'd12, 32'h0000_0801, 5'd0,  32'h0,         0, 6'b000000, 0,    32'h0000_0000, 0,   0,    32'h0000_3004));
        vecs.push_back(mk(1, 5'd14, 32'hFFFF_FFFF, 5'd4,  32'h0000_5000, 0, 6'b000010, 0,    32'h0000_3004, 1,   0,    32'h0000_3004));
        vecs.push_back(mk(0, 5'd13, 32'h0,         5'd0,  32'h0,         0, 6'b000000, 0,    32'h0000_0800, 0,   0,    32'h0000_5000));
        // eret together with mtc0 SR: write lands, then EXL cleared
        vecs.push_back(mk(1, 5'd12, 32'h0000_0C03, 5'd0,  32'h0,         0, 6'b000000, 1,    32'h0000_0803, 0,   1,    32'h0000_5000));
        vecs.push_back(mk(0, 5'd12, 32'h0,         5'd0,  32'h0,         0, 6'b000000, 0,    32'h0000_0C01, 0,   0,    32'h0000_5000));
        // EPC low bits forced to zero; Cause and unmapped writes ignored
        vecs.push_back(mk(1, 5'd14, 32'h0000_300B, 5'd0,  32'h0,         0, 6'b000000, 0,    32'h0000_5000, 0,   0,    32'h0000_5000));
        vecs.push_back(mk(0, 5'd14, 32'h0,         5'd0,  32'h0,         0, 6'b000000, 0,    32'h0000_3008, 0,   0,    32'h0000_3008));
        vecs.push_back(mk(1, 5'd13, 32'hFFFF_FFFF, 5'd0,  32'h0,         0, 6'b000000, 0,    32'h0000_0000, 0,   0,    32'h0000_3008));
        vecs.push_back(mk(1, 5'd5,  32'hFFFF_FFFF, 5'd0,  32'h0,         0, 6'b000000, 0,    32'h0000_0000, 0,   0,    32'h0000_3008));
        vecs.push_back(mk(0, 5'd13, 32'h0,         5'd0,  32'h0,         0, 6'b000000, 0,    32'h0000_0000, 0,   0,    32'h0000_3008));
        // eret loses to a simultaneous interrupt
        vecs.push_back(mk(0, 5'd12, 32'h0,         5'd0,  32'h0000_6000, 0, 6'b000001, 1,    32'h0000_0C01, 1,   0,    32'h0000_3008));

        Rst = 1'b1; ExcCode_M = '0; PC_M = '0; BD_M = 1'b0; HWInt = '0;
        WE = 1'b0; Addr = '0; DIn = '0; EXLClr = 1'b0;
        #2;
        check("reset_act", {31'd0, ActivateCP0}, 32'd0);
        check("reset_cool", {31'd0, CoolCP0}, 32'd0);
        check("handler_pc", HandlerPC, 32'h0000_4180);
        #10 Rst = 1'b0;
        @(posedge Clk); #1;

        foreach (vecs[i]) begin
            WE = vecs[i].we; Addr = vecs[i].addr; DIn = vecs[i].din;
            ExcCode_M = vecs[i].exc; PC_M = vecs[i].pc; BD_M = vecs[i].bd;
            HWInt = vecs[i].hw; EXLClr = vecs[i].exlclr;
            #1;
            check($sformatf("v%0d_dout", i), DOut, vecs[i].exp_dout);
            check($sformatf("v%0d_act", i), {31'd0, ActivateCP0}, {31'd0, vecs[i].exp_act});
            check($sformatf("v%0d_cool", i), {31'd0, CoolCP0}, {31'd0, vecs[i].exp_cool});
            check($sformatf("v%0d_epc", i), EPC_Out, vecs[i].exp_epc);
            @(posedge Clk); #1;
        end

        // In the handler (EXL = 1, EPC = 0x6000); HWInt line 0 still high.
        WE = 1'b0; Addr = 5'd12; DIn = '0; ExcCode_M = '0; PC_M = '0; EXLClr = 1'b0;
        HWInt = 6'b000001;
        #1;
        check("handler_sr", DOut, 32'h0000_0C03);
        check("handler_epc", EPC_Out, 32'h0000_6000);
        check("handler_act", {31'd0, ActivateCP0}, 32'd0);
        #1 Rst = 1'b1;
        #1;
        check("midrst_sr", DOut, 32'h0000_0000);
        check("midrst_act", {31'd0, ActivateCP0}, 32'd0);
        check("midrst_epc", EPC_Out, 32'h0000_0000);
        EXLClr = 1'b1;
        #1;
        check("midrst_cool", {31'd0, CoolCP0}, 32'd1);
        EXLClr = 1'b0;
        #1 Rst = 1'b0;
        @(posedge Clk); #1;
        Addr = 5'd13;
        #1;
        check("post_rst_ip", DOut, 32'h0000_0400);
        check("post_rst_act", {31'd0, ActivateCP0}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
